// File: rtl/ntt_4point.sv
// Two-stage pipelined 4-point NTT over Z_q (q = 7681, omega = 3383).
// Stage 1 reduces the inputs and forms the radix-2 sums/differences; stage 2 applies the twiddle.
module ntt_4point #(
    parameter int W     = 16,
    parameter int Q     = 7681,
    parameter int OMEGA = 3383
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3
);

    localparam logic [W:0]     QX = (W+1)'(Q);
    localparam logic [W+3:0]   QR = (W+4)'(Q);
    localparam logic [2*W-1:0] QP = (2*W)'(Q);
    localparam logic [2*W-1:0] OM = (2*W)'(OMEGA);

    // A 16-bit input is below 16*Q, so subtracting 8Q, 4Q, 2Q, Q conditionally fully reduces it.
    function automatic logic [W-1:0] reduce_in(input logic [W-1:0] x);
        logic [W+3:0] r;
        r = {4'b0000, x};
        for (int k = 3; k >= 0; k--) begin
            if (r >= (QR << k))
                r = r - (QR << k);
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QX)
            s = s - QX;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} - {1'b0, y};
        if (s[W])
            s = s + QX;
        return s[W-1:0];
    endfunction

    // d < Q and OMEGA < 2^W, so the product is below Q*2^W; a shift-subtract chain reduces it.
    function automatic logic [W-1:0] mul_omega(input logic [W-1:0] dv);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, dv} * OM;
        for (int k = W - 1; k >= 0; k--) begin
            if (p >= (QP << k))
                p = p - (QP << k);
        end
        return p[W-1:0];
    endfunction

    logic [W-1:0] x_raw [4];
    logic [W-1:0] x_red [4];

    assign x_raw[0] = in0;
    assign x_raw[1] = in1;
    assign x_raw[2] = in2;
    assign x_raw[3] = in3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reduce
            assign x_red[gi] = reduce_in(x_raw[gi]);
        end
    endgenerate

    logic [W-1:0] a_reg, b_reg, c_reg, d_reg;
    logic [W-1:0] a_next, b_next, c_next, d_next;
    logic [W-1:0] t_next;
    logic [W-1:0] out_reg  [4];
    logic [W-1:0] out_next [4];

    always_comb begin
        a_next = mod_add(x_red[0], x_red[2]);
        b_next = mod_sub(x_red[0], x_red[2]);
        c_next = mod_add(x_red[1], x_red[3]);
        d_next = mod_sub(x_red[1], x_red[3]);
    end

    always_comb begin
        t_next      = mul_omega(d_reg);
        out_next[0] = mod_add(a_reg, c_reg);
        out_next[1] = mod_add(b_reg, t_next);
        out_next[2] = mod_sub(a_reg, c_reg);
        out_next[3] = mod_sub(b_reg, t_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
            d_reg <= '0;
        end else begin
            a_reg <= a_next;
            b_reg <= b_next;
            c_reg <= c_next;
            d_reg <= d_next;
        end
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_out
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    out_reg[gi] <= '0;
                else
                    out_reg[gi] <= out_next[gi];
            end
        end
    endgenerate

    assign out0 = out_reg[0];
    assign out1 = out_reg[1];
    assign out2 = out_reg[2];
    assign out3 = out_reg[3];

endmodule

// File: tb/tb_ntt_4point.sv
// Bench for ntt_4point: directed vector table, async reset checks and a random stream
// compared against a direct sum-of-powers NTT model.
module tb_ntt_4point;

    localparam int Q = 7681;
    localparam int OMEGA = 3383;

    typedef logic [3:0][15:0] vec4_t;
    typedef struct {
        string name;
        vec4_t x;
        vec4_t y;
    } vec_rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic [15:0] out0, out1, out2, out3;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected outputs for the vectors applied one and two negedges ago.
    vec4_t exp1 = '0, exp2 = '0;
    string nm1 = "idle", nm2 = "idle";

    always #50 clk = ~clk;

    ntt_4point dut (
        .clk  (clk),
        .rst  (rst),
        .in0  (in0),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .out0 (out0),
        .out1 (out1),
        .out2 (out2),
        .out3 (out3)
    );

    function automatic vec4_t mk(int a, int b, int c, int d);
        vec4_t r;
        r[0] = 16'(a);
        r[1] = 16'(b);
        r[2] = 16'(c);
        r[3] = 16'(d);
        return r;
    endfunction

    // X_k = sum_j x_j * w^(j*k) mod q
    function automatic vec4_t ntt_model(vec4_t x);
        longint wp [4];
        longint acc;
        vec4_t  r;
        wp[0] = 1;
        for (int m = 1; m < 4; m++)
            wp[m] = (wp[m-1] * OMEGA) % Q;
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int j = 0; j < 4; j++)
                acc += (longint'(x[j]) % Q) * wp[(j * k) % 4];
            r[k] = 16'(acc % Q);
        end
        return r;
    endfunction

    task automatic compare(string name, vec4_t want);
        vec4_t got;
        got[0] = out0;
        got[1] = out1;
        got[2] = out2;
        got[3] = out3;
        n_checks++;
        if (got == want) begin
            n_pass++;
            $display("ok   %s: out=(%0d,%0d,%0d,%0d)", name, got[0], got[1], got[2], got[3]);
        end else begin
            $display("FAIL %s: out=(%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)", name,
                     got[0], got[1], got[2], got[3], want[0], want[1], want[2], want[3]);
        end
    endtask

    task automatic drive(vec4_t x);
        in0 = x[0];
        in1 = x[1];
        in2 = x[2];
        in3 = x[3];
    endtask

    // One transaction: check the output of the vector applied two cycles ago, then apply x.
    task automatic step(string name, vec4_t x, vec4_t want);
        @(negedge clk);
        compare(nm2, exp2);
        exp2 = exp1;
        nm2  = nm1;
        exp1 = want;
        nm1  = name;
        drive(x);
    endtask

    function automatic vec4_t rand_vec();
        vec4_t r;
        for (int j = 0; j < 4; j++)
            r[j] = 16'($urandom_range(0, Q));
        return r;
    endfunction

    // Raise rst between edges, check outputs clear at once and stay clear, release on a negedge.
    task automatic reset_pulse(int cycles);
        @(negedge clk);
        #5 rst = 1'b1;
        #1 compare("rst_async", '0);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            compare("rst_hold", '0);
            drive(rand_vec());
        end
        @(negedge clk);
        compare("rst_hold", '0);
        rst  = 1'b0;
        exp2 = '0;
        nm2  = "post_rst_zero";
        exp1 = ntt_model({in3, in2, in1, in0});
        nm1  = "post_rst_first";
    endtask

    vec_rec_t table_v [10];

    initial begin
        table_v[0] = '{"impulse",      mk(1, 0, 0, 0),                 mk(1, 1, 1, 1)};
        table_v[1] = '{"shift1",       mk(0, 1, 0, 0),                 mk(1, 3383, 7680, 4298)};
        table_v[2] = '{"shift2",       mk(0, 0, 1, 0),                 mk(1, 7680, 1, 7680)};
        table_v[3] = '{"shift3",       mk(0, 0, 0, 1),                 mk(1, 4298, 7680, 3383)};
        table_v[4] = '{"const1",       mk(1, 1, 1, 1),                 mk(4, 0, 0, 0)};
        table_v[5] = '{"constq",       mk(7681, 7681, 7681, 7681),     mk(0, 0, 0, 0)};
        table_v[6] = '{"wrap",         mk(7680, 7680, 0, 0),           mk(7679, 4297, 0, 3382)};
        table_v[7] = '{"max_in",       mk(65535, 0, 0, 0),             mk(4087, 4087, 4087, 4087)};
        table_v[8] = '{"const_m1",     mk(7680, 7680, 7680, 7680),     mk(7677, 0, 0, 0)};
        table_v[9] = '{"const_max",    mk(65535, 65535, 65535, 65535), mk(986, 0, 0, 0)};

        drive(rand_vec());
        reset_pulse(3);

        // Directed vectors back to back: also exercises full throughput.
        for (int i = 0; i < 10; i++)
            step(table_v[i].name, table_v[i].x, table_v[i].y);

        // Random stream with a mid-stream reset.
        for (int i = 0; i < 1000; i++) begin
            vec4_t x;
            x = rand_vec();
            step("rnd", x, ntt_model(x));
            if (i == 500)
                reset_pulse(2);
        end

        // Drain the last two vectors.
        step("drain", '0, '0);
        step("drain", '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
